// File: rtl/code_conv_sched.sv
// code_conv_sched: round-robin scheduler sharing one registered 4-bit
// code-conversion stage (bin->Gray, BCD->XS3, Gray->bin, XS3->BCD) among
// NREQ requesters, with a one-deep result register.
// Optional: define CONV_STATS_EN to add saturating accept/error counters.
//
// state | meaning
// EMPTY | result register holds no valid result (rsp_valid=0)
// FULL  | result register holds a result awaiting rsp_ready (rsp_valid=1)
module code_conv_sched #(
   parameter int NREQ = 4,
   parameter int IDW  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [4*NREQ-1:0] req_code,
   input  logic [2*NREQ-1:0] req_sel,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [3:0]        rsp_code,
   output logic              rsp_err
`ifdef CONV_STATS_EN
   ,
   output logic [15:0]       stat_conv_cnt,
   output logic [15:0]       stat_err_cnt
`endif
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t              state;
   logic [IDW-1:0]      rr_ptr;
   logic                can_accept;
   logic                accept;
   logic                gnt_found;
   logic [IDW-1:0]      gnt_idx;
   logic [2*NREQ-1:0]   valid_rot;
   int                  scan_sum;
   logic [3:0]          win_code;
   logic [1:0]          win_sel;
   logic [4:0]          conv_res;

   // Returns {err, code}; illegal inputs yield code 0 so no X ever escapes.
   function automatic logic [4:0] convert(input logic [3:0] x, input logic [1:0] sel);
      logic [3:0] b;
      logic [4:0] r;
      b = '0;
      r = '0;
      case (sel)
         2'b00: r = {1'b0, x[3], x[3] ^ x[2], x[2] ^ x[1], x[1] ^ x[0]};
         2'b01: r = (x <= 4'd9) ? {1'b0, x + 4'd3} : 5'b1_0000;
         2'b10: begin
            b[3] = x[3];
            b[2] = b[3] ^ x[2];
            b[1] = b[2] ^ x[1];
            b[0] = b[1] ^ x[0];
            r    = {1'b0, b};
         end
         default: r = (x >= 4'd3 && x <= 4'd12) ? {1'b0, x - 4'd3} : 5'b1_0000;
      endcase
      return r;
   endfunction

   assign rsp_valid  = (state == FULL);
   assign can_accept = !rsp_valid || rsp_ready;

   // Round-robin scan: rotate the doubled valid vector so position 0 is rr_ptr.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      scan_sum  = 0;
      valid_rot = {req_valid, req_valid} >> rr_ptr;
      for (int k = 0; k < NREQ; k++) begin
         if (!gnt_found && valid_rot[k]) begin
            gnt_found = 1'b1;
            scan_sum  = int'(rr_ptr) + k;
            if (scan_sum >= NREQ) scan_sum = scan_sum - NREQ;
            gnt_idx   = IDW'(scan_sum);
         end
      end
   end

   // Winner data mux and one-hot ready; ready is forced low while in reset.
   always_comb begin
      win_code  = '0;
      win_sel   = '0;
      req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_idx == IDW'(i)) begin
            win_code     = req_code[4*i +: 4];
            win_sel      = req_sel[2*i +: 2];
            req_ready[i] = rst_n && can_accept && gnt_found;
         end
      end
   end

   assign conv_res = convert(win_code, win_sel);
   assign accept   = |(req_valid & req_ready);

   // Result register, state and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMPTY;
         rsp_id   <= '0;
         rsp_code <= '0;
         rsp_err  <= 1'b0;
         rr_ptr   <= '0;
      end else if (accept) begin
         state    <= FULL;
         rsp_id   <= gnt_idx;
         rsp_code <= conv_res[3:0];
         rsp_err  <= conv_res[4];
         rr_ptr   <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
      end else if (state == FULL && rsp_ready) begin
         state    <= EMPTY;
      end
   end

`ifdef CONV_STATS_EN
   // Saturating counters of accepted requests and of those flagged as errors.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_conv_cnt <= '0;
         stat_err_cnt  <= '0;
      end else if (accept) begin
         if (stat_conv_cnt != 16'hFFFF) stat_conv_cnt <= stat_conv_cnt + 16'd1;
         if (conv_res[4] && stat_err_cnt != 16'hFFFF) stat_err_cnt <= stat_err_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_code_conv_sched.sv
// Bench for code_conv_sched: scoreboard of expected results, pushed when a
// request is expected to be accepted and compared while the result is held.
module tb_code_conv_sched;
   localparam int NREQ = 4;
   localparam int IDW  = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ-1:0]   req_ready;
   logic [4*NREQ-1:0] req_code = '0;
   logic [2*NREQ-1:0] req_sel = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [IDW-1:0]    rsp_id;
   logic [3:0]        rsp_code;
   logic              rsp_err;
`ifdef CONV_STATS_EN
   logic [15:0]       stat_conv_cnt;
   logic [15:0]       stat_err_cnt;
`endif

   code_conv_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_code(req_code), .req_sel(req_sel),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_code(rsp_code), .rsp_err(rsp_err)
`ifdef CONV_STATS_EN
      , .stat_conv_cnt(stat_conv_cnt), .stat_err_cnt(stat_err_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [3:0]     code;
      logic           err;
   } rsp_t;

   rsp_t q[$];
   int total = 0;
   int bad = 0;
   int m_ptr = 0;
   int m_conv = 0;
   int m_err = 0;

   function automatic logic [4:0] model(input logic [3:0] x, input logic [1:0] s);
      logic [3:0] b;
      case (s)
         2'd0: return {1'b0, x ^ (x >> 1)};
         2'd1: return (x <= 4'd9) ? {1'b0, x + 4'd3} : 5'b1_0000;
         2'd2: begin
            b[3] = x[3];
            for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ x[i];
            return {1'b0, b};
         end
         default: return (x >= 4'd3 && x <= 4'd12) ? {1'b0, x - 4'd3} : 5'b1_0000;
      endcase
   endfunction

   function automatic int exp_winner(input logic [NREQ-1:0] v, input int ptr);
      for (int k = 0; k < NREQ; k++)
         if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      return -1;
   endfunction

   function automatic rsp_t exp_rsp(input int w);
      logic [4*NREQ-1:0] c;
      logic [2*NREQ-1:0] s;
      logic [4:0] r;
      c = req_code >> (4*w);
      s = req_sel >> (2*w);
      r = model(c[3:0], s[1:0]);
      return {IDW'(w), r[3:0], r[4]};
   endfunction

   task automatic test_reset;
      req_valid = '1;
      rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #3;
      total++;
      if ({rsp_valid, rsp_id, rsp_code, rsp_err} !== '0) begin
         bad++;
         $display("FAIL reset_rsp got v=%b id=%0d code=%h err=%b want all 0", rsp_valid, rsp_id, rsp_code, rsp_err);
      end
      total++;
      if (req_ready !== '0) begin
         bad++;
         $display("FAIL reset_ready got %b want 0000", req_ready);
      end
      req_valid = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      q.delete(); m_ptr = 0; m_conv = 0; m_err = 0;
   endtask

   task automatic test_convert;
      logic [3:0] codes [11] = '{4'b1011, 4'b1110, 4'd9, 4'd10, 4'd3, 4'd13, 4'd15, 4'd0, 4'd12, 4'd2, 4'b0110};
      logic [1:0] sels  [11] = '{2'd0, 2'd2, 2'd1, 2'd1, 2'd3, 2'd3, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
      logic [NREQ-1:0] exp_rdy;
      logic can;
      int w;
      rsp_t r;
      rsp_ready = 1'b1;
      for (int n = 0; n < 13; n++) begin
         req_valid = (n < 11) ? NREQ'(1) : '0;
         req_code  = {12'h5A3, (n < 11) ? codes[n] : 4'h0};
         req_sel   = {6'b011011, (n < 11) ? sels[n] : 2'b00};
         #2;
         can = (q.size() == 0) || rsp_ready;
         w = exp_winner(req_valid, m_ptr);
         exp_rdy = (w >= 0 && can) ? (NREQ'(1) << w) : '0;
         total++;
         if (req_ready !== exp_rdy) begin
            bad++;
            $display("FAIL conv_ready n=%0d got %b want %b", n, req_ready, exp_rdy);
         end
         total++;
         if (q.size() > 0) begin
            if ({rsp_valid, rsp_id, rsp_code, rsp_err} !== {1'b1, q[0]}) begin
               bad++;
               $display("FAIL conv_rsp n=%0d got v=%b id=%0d code=%h err=%b want id=%0d code=%h err=%b",
                        n, rsp_valid, rsp_id, rsp_code, rsp_err, q[0].id, q[0].code, q[0].err);
            end
            if (rsp_ready) void'(q.pop_front());
         end else if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL conv_empty n=%0d got rsp_valid=%b want 0", n, rsp_valid);
         end
         if (w >= 0 && can) begin
            r = exp_rsp(w);
            q.push_back(r);
            m_ptr = (w + 1) % NREQ;
            m_conv++;
            if (r.err) m_err++;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_stats;
`ifdef CONV_STATS_EN
      total++;
      if (stat_conv_cnt !== 16'(m_conv) || stat_err_cnt !== 16'(m_err)) begin
         bad++;
         $display("FAIL stats got conv=%0d err=%0d want conv=%0d err=%0d", stat_conv_cnt, stat_err_cnt, m_conv, m_err);
      end
`endif
   endtask

   task automatic test_reset_mid;
      req_valid = 4'b0100;
      req_code  = 16'h0500;
      req_sel   = 8'h00;
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = '1;
      rsp_ready = 1'b1;
      #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== IDW'(2) || rsp_code !== 4'h7) begin
         bad++;
         $display("FAIL mid_full got v=%b id=%0d code=%h want v=1 id=2 code=7", rsp_valid, rsp_id, rsp_code);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if ({rsp_valid, rsp_id, rsp_code, rsp_err} !== '0 || req_ready !== '0) begin
         bad++;
         $display("FAIL mid_reset got v=%b id=%0d code=%h err=%b rdy=%b want all 0",
                  rsp_valid, rsp_id, rsp_code, rsp_err, req_ready);
      end
      @(posedge clk); #1;
      req_valid = '0;
      rst_n = 1'b1;
      q.delete(); m_ptr = 0; m_conv = 0; m_err = 0;
   endtask

   task automatic test_round_robin;
      logic [NREQ-1:0] exp_rdy;
      logic can;
      int w;
      rsp_t r;
      req_code  = {4'h9, 4'hC, 4'h5, 4'h7};
      req_sel   = {2'd3, 2'd2, 2'd1, 2'd0};
      rsp_ready = 1'b1;
      for (int n = 0; n < 7; n++) begin
         req_valid = (n < 5) ? '1 : '0;
         #2;
         can = (q.size() == 0) || rsp_ready;
         w = exp_winner(req_valid, m_ptr);
         exp_rdy = (w >= 0 && can) ? (NREQ'(1) << w) : '0;
         total++;
         if (req_ready !== exp_rdy) begin
            bad++;
            $display("FAIL rr_ready n=%0d got %b want %b", n, req_ready, exp_rdy);
         end
         if (n < 5) begin
            total++;
            if (req_ready !== (NREQ'(1) << (n % NREQ))) begin
               bad++;
               $display("FAIL rr_order n=%0d got %b want id %0d", n, req_ready, n % NREQ);
            end
         end
         total++;
         if (q.size() > 0) begin
            if ({rsp_valid, rsp_id, rsp_code, rsp_err} !== {1'b1, q[0]}) begin
               bad++;
               $display("FAIL rr_rsp n=%0d got v=%b id=%0d code=%h err=%b want id=%0d code=%h err=%b",
                        n, rsp_valid, rsp_id, rsp_code, rsp_err, q[0].id, q[0].code, q[0].err);
            end
            if (rsp_ready) void'(q.pop_front());
         end else if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rr_empty n=%0d got rsp_valid=%b want 0", n, rsp_valid);
         end
         if (w >= 0 && can) begin
            r = exp_rsp(w);
            q.push_back(r);
            m_ptr = (w + 1) % NREQ;
            m_conv++;
            if (r.err) m_err++;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure;
      logic [NREQ-1:0] vals [10] = '{4'b1000, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110,
                                    4'b0110, 4'b0100, 4'b0000, 4'b0000};
      logic            rdys [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [NREQ-1:0] exp_rdy;
      logic can;
      int w;
      rsp_t r;
      req_code = {4'd12, 4'd9, 4'd4, 4'd0};
      req_sel  = {2'd3, 2'd1, 2'd2, 2'd0};
      for (int n = 0; n < 10; n++) begin
         req_valid = vals[n];
         rsp_ready = rdys[n];
         #2;
         can = (q.size() == 0) || rsp_ready;
         w = exp_winner(req_valid, m_ptr);
         exp_rdy = (w >= 0 && can) ? (NREQ'(1) << w) : '0;
         total++;
         if (req_ready !== exp_rdy) begin
            bad++;
            $display("FAIL bp_ready n=%0d got %b want %b", n, req_ready, exp_rdy);
         end
         if (n == 6) begin
            total++;
            if (req_ready !== 4'b0010) begin
               bad++;
               $display("FAIL bp_release got %b want 0010", req_ready);
            end
         end
         total++;
         if (q.size() > 0) begin
            if ({rsp_valid, rsp_id, rsp_code, rsp_err} !== {1'b1, q[0]}) begin
               bad++;
               $display("FAIL bp_rsp n=%0d got v=%b id=%0d code=%h err=%b want id=%0d code=%h err=%b",
                        n, rsp_valid, rsp_id, rsp_code, rsp_err, q[0].id, q[0].code, q[0].err);
            end
            if (rsp_ready) void'(q.pop_front());
         end else if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_empty n=%0d got rsp_valid=%b want 0", n, rsp_valid);
         end
         if (w >= 0 && can) begin
            r = exp_rsp(w);
            q.push_back(r);
            m_ptr = (w + 1) % NREQ;
            m_conv++;
            if (r.err) m_err++;
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_convert();
      test_stats();
      test_reset_mid();
      test_round_robin();
      test_backpressure();
      test_stats();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
